// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive front-end: FSM states,
// oversampling constants and the default tick divider.
package uart_rx_fifo_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_e;

   localparam int         OVERSAMPLE  = 16;
   localparam logic [3:0] MID_SAMPLE  = 4'd7;
   localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

   // 50 MHz / (115200 baud * 16) rounds down to 27
   localparam int DIV_DEFAULT = 27;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Pop/status bundle between the receive front-end and the UART register block.
interface uart_rx_fifo_if;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic       rx_full;
   logic       frame_err;
   logic       overrun;
   logic       rx_irq;

   modport master (
      output rd_en, clr_err,
      input  rd_data, rx_valid, rx_full, frame_err, overrun, rx_irq
   );

   modport slave (
      input  rd_en, clr_err,
      output rd_data, rx_valid, rx_full, frame_err, overrun, rx_irq
   );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead byte FIFO; dout shows the head entry and reads 0 when empty.
module sync_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] head_r;
   logic [AW-1:0] tail_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign empty     = (count_r == {(AW + 1){1'b0}});
   assign full      = (count_r == FULL_CNT);
   assign do_pop_s  = pop & ~empty;
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign do_push_s = push & (~full | do_pop_s);
   assign dout      = empty ? 8'd0 : mem_r[head_r];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= {AW{1'b0}};
         tail_r  <= {AW{1'b0}};
         count_r <= {(AW + 1){1'b0}};
      end else begin
         if (do_pop_s) begin
            head_r <= head_r + AW'(1);
         end
         if (do_push_s) begin
            tail_r <= tail_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW + 1)'(1);
            2'b01:   count_r <= count_r - (AW + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'd0;
         end
      end else if (do_push_s) begin
         mem_r[tail_r] <= din;
      end
   end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, feeding a small show-ahead FIFO
// with sticky frame/overrun flags and a combined interrupt level.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DIV   = DIV_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic          sysclk,
   input  logic          reset,
   input  logic          uart_rx,
   uart_rx_fifo_if.slave bus
);
   localparam int            DW       = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic          sync1_r;
   logic          rxs_r;
   logic [DW-1:0] div_cnt_r;
   logic          tick_s;
   rx_state_e     state_r;
   logic [3:0]    smp_r;
   logic [2:0]    bit_idx_r;
   logic [7:0]    shift_r;
   logic          push_r;
   logic          frame_err_r;
   logic          overrun_r;
   logic          pop_s;
   logic          empty_s;
   logic          full_s;
   logic [7:0]    dout_s;

   assign tick_s = (div_cnt_r == DIV_LAST);
   assign pop_s  = bus.rd_en & ~empty_s;

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 1'b1;
         rxs_r   <= 1'b1;
      end else begin
         sync1_r <= uart_rx;
         rxs_r   <= sync1_r;
      end
   end

   // Free-running oversample tick divider
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         div_cnt_r <= {DW{1'b0}};
      end else if (tick_s) begin
         div_cnt_r <= {DW{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + DW'(1);
      end
   end

   // Deframing FSM; error sets are written after the clear so a set wins
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         smp_r       <= 4'd0;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'd0;
         push_r      <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         push_r <= 1'b0;
         if (bus.clr_err) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (tick_s && !rxs_r) begin
                  state_r <= START;
                  smp_r   <= 4'd0;
               end
            end
            START: begin
               if (tick_s) begin
                  if (smp_r == MID_SAMPLE) begin
                     if (rxs_r) begin
                        state_r <= IDLE;
                     end else begin
                        smp_r     <= 4'd0;
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                     end
                  end else begin
                     smp_r <= smp_r + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (smp_r == LAST_SAMPLE) begin
                     shift_r[bit_idx_r] <= rxs_r;
                     smp_r              <= 4'd0;
                     if (bit_idx_r == 3'd7) begin
                        state_r <= STOP;
                     end else begin
                        bit_idx_r <= bit_idx_r + 3'd1;
                     end
                  end else begin
                     smp_r <= smp_r + 4'd1;
                  end
               end
            end
            STOP: begin
               if (tick_s) begin
                  if (smp_r == LAST_SAMPLE) begin
                     smp_r <= 4'd0;
                     if (rxs_r) begin
                        if (!full_s || pop_s) begin
                           push_r <= 1'b1;
                        end else begin
                           overrun_r <= 1'b1;
                        end
                        state_r <= IDLE;
                     end else begin
                        frame_err_r <= 1'b1;
                        state_r     <= BREAK;
                     end
                  end else begin
                     smp_r <= smp_r + 4'd1;
                  end
               end
            end
            BREAK: begin
               if (rxs_r) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (sysclk),
      .rst_n (reset),
      .push  (push_r),
      .pop   (pop_s),
      .din   (shift_r),
      .dout  (dout_s),
      .empty (empty_s),
      .full  (full_s)
   );

   assign bus.rd_data   = dout_s;
   assign bus.rx_valid  = ~empty_s;
   assign bus.rx_full   = full_s;
   assign bus.frame_err = frame_err_r;
   assign bus.overrun   = overrun_r;
   assign bus.rx_irq    = ~empty_s | frame_err_r | overrun_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: frames are serialised onto uart_rx, a queue model of the
// FIFO predicts contents and flags, and a monitor checks every accepted pop.
module tb_uart_rx_fifo;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;
   localparam int BIT   = 64;

   logic sysclk  = 1'b0;
   logic reset   = 1'b0;
   logic uart_rx = 1'b1;

   uart_rx_fifo_if bus ();

   uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH)) dut (
      .sysclk  (sysclk),
      .reset   (reset),
      .uart_rx (uart_rx),
      .bus     (bus)
   );

   always #5 sysclk = ~sysclk;

   // edges since reset release; oversample ticks fall on edges where cyc % 4 == 0
   int cyc;
   always @(posedge sysclk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   bit         fe_exp = 1'b0;
   bit         ov_exp = 1'b0;
   bit         auto_rd = 1'b0;
   int         manual_pops = 0;
   int         pop_at = -1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   // Reader: the only driver of rd_en
   initial begin
      bus.rd_en = 1'b0;
      forever begin
         @(posedge sysclk);
         #1;
         bus.rd_en = 1'b0;
         if (pop_at >= 0 && cyc + 1 == pop_at) begin
            bus.rd_en = 1'b1;
            pop_at    = -1;
         end else if (manual_pops > 0 && bus.rx_valid) begin
            bus.rd_en = 1'b1;
            manual_pops--;
         end else if (auto_rd && bus.rx_valid) begin
            bus.rd_en = 1'b1;
         end
      end
   end

   // Monitor: every accepted pop must return the model's head byte
   initial begin
      forever begin
         @(negedge sysclk);
         if (reset && bus.rd_en && bus.rx_valid) begin
            if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
            else                   check("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic check_state(input string tag);
      bit v;
      v = (exp_q.size() != 0);
      check({tag, "_valid"}, 32'(bus.rx_valid), 32'(v));
      check({tag, "_full"}, 32'(bus.rx_full), 32'(exp_q.size() >= DEPTH));
      check({tag, "_frame_err"}, 32'(bus.frame_err), 32'(fe_exp));
      check({tag, "_overrun"}, 32'(bus.overrun), 32'(ov_exp));
      check({tag, "_irq"}, 32'(bus.rx_irq), 32'(v | fe_exp | ov_exp));
      check({tag, "_rd_data"}, 32'(bus.rd_data), v ? 32'(exp_q[0]) : 32'd0);
   endtask

   task automatic wait_pops(input string tag);
      int budget;
      budget = 200;
      while (manual_pops > 0 && budget > 0) begin
         @(posedge sysclk);
         #1;
         budget--;
      end
      check({tag, "_pops_done"}, 32'(manual_pops), 32'd0);
      wait_cyc(2);
   endtask

   // Serialise one frame; the model is updated as the stop bit begins
   task automatic send_frame(input logic [7:0] d, input bit stop, input bit pop_stop, input bit chk_lat);
      int j, dd, s, pre;
      @(posedge sysclk);
      #1;
      j       = cyc;
      uart_rx = 1'b0;
      dd = j + 3;
      while (dd % DIV != 0) dd++;
      s = dd + 8 * DIV + 9 * 16 * DIV;
      if (pop_stop) pop_at = s;
      wait_cyc(BIT);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         wait_cyc(BIT);
      end
      uart_rx = stop;
      pre = exp_q.size();
      if (stop) begin
         if (pre < DEPTH || pop_stop) exp_q.push_back(d);
         else                         ov_exp = 1'b1;
      end else begin
         fe_exp = 1'b1;
      end
      if (chk_lat) begin
         while (cyc < s) begin
            @(posedge sysclk);
            #1;
         end
         check("latency_at_sample", 32'(bus.rx_valid), 32'd0);
         wait_cyc(1);
         check("latency_after_sample", 32'(bus.rx_valid), 32'd1);
      end
      while (cyc < j + 10 * BIT) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, expected to finish by 2 ms");
      $fatal(1);
   end

   initial begin
      bus.clr_err = 1'b0;
      wait_cyc(3);
      check_state("reset");
      @(negedge sysclk);
      reset = 1'b1;
      wait_cyc(20);

      // single frame, latency, pop back to empty
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      check_state("a5");
      manual_pops = 1;
      wait_pops("a5");
      check_state("a5_popped");

      // short low glitch is a false start
      uart_rx = 1'b0;
      wait_cyc(20);
      uart_rx = 1'b1;
      wait_cyc(200);
      check_state("glitch");

      // framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      wait_cyc(200);
      check_state("break");
      bus.clr_err = 1'b1;
      wait_cyc(1);
      bus.clr_err = 1'b0;
      fe_exp = 1'b0;
      wait_cyc(300);
      check_state("break_cleared");
      uart_rx = 1'b1;
      wait_cyc(100);
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      check_state("x55");
      manual_pops = 1;
      wait_pops("x55");

      // fill, overrun, drain
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      check_state("full4");
      send_frame(8'h05, 1'b1, 1'b0, 1'b0);
      check_state("overrun");
      manual_pops = 4;
      wait_pops("drain1");
      check_state("drained1");
      bus.clr_err = 1'b1;
      wait_cyc(1);
      bus.clr_err = 1'b0;
      ov_exp = 1'b0;
      check_state("ov_cleared");

      // pop on the exact stop-sample cycle of a full FIFO
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      send_frame(8'h05, 1'b1, 1'b1, 1'b0);
      check_state("same_cycle");
      manual_pops = 4;
      wait_pops("drain2");
      check_state("drained2");

      // randomized traffic with a reader that drains continuously
      auto_rd = 1'b1;
      for (int k = 0; k < 10; k++) begin
         wait_cyc($urandom_range(0, 30));
         send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
         check_state("rand");
      end
      auto_rd = 1'b0;

      // reset in the middle of a character
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      check_state("pre_reset");
      uart_rx = 1'b0;
      wait_cyc(BIT);
      for (int i = 0; i < 4; i++) begin
         uart_rx = 1'(8'h99 >> i);
         wait_cyc(BIT);
      end
      uart_rx = 1'b1;
      wait_cyc(BIT / 2);
      reset = 1'b0;
      exp_q.delete();
      fe_exp = 1'b0;
      ov_exp = 1'b0;
      #1;
      check_state("mid_reset");
      wait_cyc(10);
      @(negedge sysclk);
      reset = 1'b1;
      wait_cyc(20);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
      check_state("x7e");
      manual_pops = 1;
      wait_pops("x7e");
      check_state("final");
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
